// File: rtl/ldpc_rd_sched_pkg.sv
// ldpc_rd_sched_pkg: shared constants for the LDPC read-address scheduler.
//   - default widths (address, row index, iteration count, row count)
//   - rd_cell beat codes driven on 'cycle'
//   - scheduler FSM state encoding
package ldpc_rd_sched_pkg;

  localparam int unsigned A_WID_DEF   = 8;
  localparam int unsigned R_WID_DEF   = 6;
  localparam int unsigned I_WID_DEF   = 4;
  localparam int unsigned ROW_NUM_DEF = 48;

  // Beat codes seen by rd_cell; CYC_NONE whenever en is low.
  localparam logic [1:0] CYC_NONE = 2'b00;
  localparam logic [1:0] CYC_1    = 2'b01;
  localparam logic [1:0] CYC_2    = 2'b10;
  localparam logic [1:0] CYC_3    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/ldpc_rd_sched_if.sv
// ldpc_rd_sched_if: bundle between the scheduler, its row-descriptor ROM and
// the rd_cell bank.
//   tbl_rd/tbl_addr     scheduler -> ROM read strobe and row address
//   tbl_data            ROM -> scheduler {base, off1, off2, off3}
//   en/cycle            scheduler -> rd_cell beat strobe and beat code
//   base_addr/addr_offset scheduler -> rd_cell descriptor registers
//   stall               rd_cell side -> scheduler back-pressure
// master = scheduler side, slave = ROM / rd_cell side.
interface ldpc_rd_sched_if #(
  parameter int unsigned A_WID = 8,
  parameter int unsigned R_WID = 6
) ();

  logic               tbl_rd;
  logic [R_WID-1:0]   tbl_addr;
  logic [4*A_WID-1:0] tbl_data;
  logic               en;
  logic [1:0]         cycle;
  logic [A_WID-1:0]   base_addr;
  logic [3*A_WID-1:0] addr_offset;
  logic               stall;

  modport master (
    output tbl_rd, tbl_addr, en, cycle, base_addr, addr_offset,
    input  tbl_data, stall
  );

  modport slave (
    input  tbl_rd, tbl_addr, en, cycle, base_addr, addr_offset,
    output tbl_data, stall
  );

endinterface

// File: rtl/ldpc_rd_sched.sv
// ldpc_rd_sched: walks every row of the parity-check matrix for N iterations,
// fetching each row descriptor from a synchronous ROM and issuing three
// en/cycle beats per row to rd_cell. The next descriptor is prefetched during
// beat 2 so rows follow each other with no bubble.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, abort    pass start pulse (IDLE only) and synchronous abort
//   iter_max        iterations for the pass (0 runs one)
//   busy, done      pass in progress, one-cycle completion pulse
//   row_idx         row currently issuing
//   iter_cnt        iteration currently issuing, 0-based
//   bus             ROM and rd_cell signals (master side)
module ldpc_rd_sched
  import ldpc_rd_sched_pkg::*;
#(
  parameter int unsigned A_WID   = A_WID_DEF,
  parameter int unsigned R_WID   = R_WID_DEF,
  parameter int unsigned ROW_NUM = ROW_NUM_DEF,
  parameter int unsigned I_WID   = I_WID_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [I_WID-1:0]     iter_max,
  output logic                 busy,
  output logic                 done,
  output logic [R_WID-1:0]     row_idx,
  output logic [I_WID-1:0]     iter_cnt,
  ldpc_rd_sched_if.master      bus
);

  localparam logic [R_WID-1:0] ROW_LAST = R_WID'(ROW_NUM - 1);

  sched_state_t       state_q, state_nxt;
  logic [1:0]         cyc_q;
  logic [R_WID-1:0]   row_q;
  logic [I_WID-1:0]   iter_q;
  logic [I_WID-1:0]   iter_lim_q;
  logic               busy_q;
  logic               done_q;
  logic [A_WID-1:0]   base_q;
  logic [3*A_WID-1:0] off_q;

  logic               en_c;
  logic [1:0]         cycle_c;
  logic               tbl_rd_c;
  logic [R_WID-1:0]   tbl_addr_c;

  logic               last_row;
  logic               last_iter;
  logic               final_row;
  logic [R_WID-1:0]   next_row;
  logic               beat_adv;

  // Row / iteration position helpers
  assign last_row  = (row_q == ROW_LAST);
  assign last_iter = (iter_q == (iter_lim_q - I_WID'(1)));
  assign final_row = last_row && last_iter;
  assign next_row  = last_row ? '0 : (row_q + R_WID'(1));
  assign beat_adv  = (state_q == ST_ISSUE) && !bus.stall;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // Next state and combinational ROM / rd_cell strobes
  always_comb begin
    state_nxt  = state_q;
    en_c       = 1'b0;
    cycle_c    = CYC_NONE;
    tbl_rd_c   = 1'b0;
    tbl_addr_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        tbl_rd_c   = 1'b1;
        tbl_addr_c = '0;
        state_nxt  = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        en_c    = !bus.stall;
        cycle_c = en_c ? cyc_q : CYC_NONE;
        // Prefetch during beat 2 so the descriptor is ready at the end of beat 3
        if (beat_adv && (cyc_q == CYC_2) && !final_row) begin
          tbl_rd_c   = 1'b1;
          tbl_addr_c = next_row;
        end
        if (beat_adv && (cyc_q == CYC_3) && final_row) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Abort overrides every transition, including a same-cycle start
    if (abort) state_nxt = ST_IDLE;
  end

  // Counters, descriptor registers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q      <= CYC_NONE;
      row_q      <= '0;
      iter_q     <= '0;
      iter_lim_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      off_q      <= '0;
    end else begin
      done_q <= (state_nxt == ST_DONE);
      if (abort) begin
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              busy_q     <= 1'b1;
              row_q      <= '0;
              iter_q     <= '0;
              iter_lim_q <= (iter_max == '0) ? I_WID'(1) : iter_max;
            end
          end
          ST_LOAD: begin
            base_q <= bus.tbl_data[4*A_WID-1 -: A_WID];
            off_q  <= bus.tbl_data[3*A_WID-1:0];
            cyc_q  <= CYC_1;
          end
          ST_ISSUE: begin
            if (beat_adv) begin
              if (cyc_q == CYC_3) begin
                cyc_q <= CYC_1;
                // Final row keeps its descriptor; nothing was prefetched
                if (!final_row) begin
                  base_q <= bus.tbl_data[4*A_WID-1 -: A_WID];
                  off_q  <= bus.tbl_data[3*A_WID-1:0];
                  row_q  <= next_row;
                  if (last_row) iter_q <= iter_q + I_WID'(1);
                end
              end else begin
                cyc_q <= cyc_q + 2'd1;
              end
            end
          end
          ST_DONE: begin
            busy_q <= 1'b0;
          end
          default: begin
            busy_q <= busy_q;
          end
        endcase
      end
    end
  end

  assign bus.en          = en_c;
  assign bus.cycle       = cycle_c;
  assign bus.tbl_rd      = tbl_rd_c;
  assign bus.tbl_addr    = tbl_addr_c;
  assign bus.base_addr   = base_q;
  assign bus.addr_offset = off_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign row_idx         = row_q;
  assign iter_cnt        = iter_q;

endmodule

// File: tb/tb_ldpc_rd_sched.sv
// tb_ldpc_rd_sched: scoreboard bench for ldpc_rd_sched with a 4-row ROM model.
// Expected beats are queued when a pass starts and popped on every en beat.
module tb_ldpc_rd_sched;

  localparam int unsigned A_WID   = 8;
  localparam int unsigned R_WID   = 6;
  localparam int unsigned I_WID   = 4;
  localparam int unsigned ROW_NUM = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [I_WID-1:0] iter_max;
  logic             busy;
  logic             done;
  logic [R_WID-1:0] row_idx;
  logic [I_WID-1:0] iter_cnt;

  ldpc_rd_sched_if #(.A_WID(A_WID), .R_WID(R_WID)) bus ();

  ldpc_rd_sched #(
    .A_WID(A_WID), .R_WID(R_WID), .ROW_NUM(ROW_NUM), .I_WID(I_WID)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .iter_max(iter_max), .busy(busy), .done(done),
    .row_idx(row_idx), .iter_cnt(iter_cnt), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ROM row r = {8'h10*r, 1, 2, 3}
  function automatic logic [31:0] rom_word(input logic [R_WID-1:0] r);
    logic [7:0] b;
    b = 8'(r) << 4;
    return {b, 8'd1, 8'd2, 8'd3};
  endfunction

  // {base, offsets, cycle, row, iter}
  function automatic logic [43:0] mk_beat(input int r, input int k, input int i);
    return {rom_word(R_WID'(r)), 2'(k), R_WID'(r), I_WID'(i)};
  endfunction

  always @(posedge clk) begin
    if (bus.tbl_rd) bus.tbl_data <= rom_word(bus.tbl_addr);
  end

  logic [43:0] sb[$];
  int tcnt = 0;
  int t_start = 0;
  int first_en_t = 0;
  bit first_pend = 0;
  int done_n = 0;
  int done_t = 0;
  int d0 = 0;

  always @(posedge clk) tcnt <= tcnt + 1;

  // Output monitor
  always @(negedge clk) begin
    logic [43:0] obs;
    logic [43:0] exp;
    if (bus.en) begin
      obs = {bus.base_addr, bus.addr_offset, bus.cycle, row_idx, iter_cnt};
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("beat", 64'(obs), 64'(exp));
      if (first_pend) begin
        first_en_t = tcnt;
        first_pend = 0;
      end
    end else begin
      chk("cyc_off", 64'(bus.cycle), 64'd0);
    end
    if (bus.stall && busy) chk("stall_en", 64'(bus.en), 64'd0);
    if (done) begin
      done_n++;
      done_t = tcnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int im);
    int n;
    n = (im == 0) ? 1 : im;
    for (int i = 0; i < n; i++)
      for (int r = 0; r < int'(ROW_NUM); r++)
        for (int k = 1; k <= 3; k++)
          sb.push_back(mk_beat(r, k, i));
    iter_max   = I_WID'(im);
    d0         = done_n;
    t_start    = tcnt;
    first_pend = 1;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 400 && done_n == d0; n++) tick();
    repeat (3) tick();
    chk({tag, "_done"}, 64'(done_n - d0), 64'd1);
    chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_pos(input logic [R_WID-1:0] r, input logic [1:0] c, input string tag);
    int n;
    n = 0;
    while (!(bus.en && row_idx == r && bus.cycle == c) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 64'(n < 100), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({bus.tbl_rd, bus.tbl_addr, bus.en, bus.cycle, bus.base_addr,
                  bus.addr_offset, busy, done, row_idx, iter_cnt}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; iter_max = '0;
    bus.stall = 1'b0;
    repeat (3) tick();
    chk_zero("reset_state");
    reset = 1'b0;
    tick();

    // Single iteration, latency of first beat and done
    start_pass(1);
    wait_done("t1");
    chk("t1_first_en", 64'(first_en_t - t_start), 64'd3);
    chk("t1_done_t", 64'(done_t - t_start), 64'd15);
    chk("t1_iter_hold", 64'(iter_cnt), 64'd0);

    // Three iterations, wrap with no bubble
    start_pass(3);
    wait_done("t2");
    chk("t2_done_t", 64'(done_t - t_start), 64'd39);

    // Stall for 4 clk at beat 3 of row 1
    start_pass(1);
    wait_pos(R_WID'(1), 2'd3, "t3");
    bus.stall = 1'b1;
    repeat (4) tick();
    bus.stall = 1'b0;
    wait_done("t3");
    chk("t3_done_t", 64'(done_t - t_start), 64'd19);

    // iter_max = 0 runs once; restart mid-pass ignored
    start_pass(0);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4");

    // Abort during row 2
    start_pass(1);
    wait_pos(R_WID'(2), 2'd1, "t5");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_en", 64'(bus.en), 64'd0);
    chk("t5_left", 64'(sb.size()), 64'd5);
    sb.delete();
    d0 = done_n;
    repeat (5) tick();
    chk("t5_nodone", 64'(done_n - d0), 64'd0);
    start_pass(1);
    wait_done("t5r");

    // Start with abort in the same clock stays idle
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("t5_abort_wins", 64'(busy), 64'd0);

    // Reset mid-pass
    start_pass(2);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    chk_zero("t6_async");
    sb.delete();
    d0 = done_n;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("t6_nodone", 64'(done_n - d0), 64'd0);
    chk_zero("t6_idle");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
